// File: rtl/reg_cmd_driver.sv
// reg_cmd_driver
//   Command-level driver for a WIDTH-bit control register. Takes one command per
//   cmd_valid/cmd_ready handshake, expands it into single-cycle control pulses,
//   tracks a shadow copy of the register and compares the real register output
//   against that copy once the command has finished.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE, low during rst)
//   cmd_op                   0 CLR,1 LD,2 INC,3 DEC,4 SHR,5 SHL,6 ROR,7 ROL
//   cmd_arg                  LD data; bit0 is serial-in bit for SHR/SHL
//   cmd_cnt                  repeat count for ops 2..7 (0 = no pulses)
//   reg_cl..reg_il, reg_in   register controls and parallel data
//   reg_out                  register output, checked against the shadow model
//   done, err                done pulses once per command; err valid with done, then held
//   exp_val                  shadow model value
//   err_count                saturating count of mismatching commands
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | one control pulse per cycle, pulse counter running down
// CHECK | register settled, compare reg_out to shadow, done high

module reg_cmd_driver #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [WIDTH-1:0] cmd_cnt,
  output logic             reg_cl,
  output logic             reg_ld,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_sr,
  output logic             reg_ir,
  output logic             reg_sl,
  output logic             reg_il,
  output logic [WIDTH-1:0] reg_in,
  input  logic [WIDTH-1:0] reg_out,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] exp_val,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_ROR = 3'd6;
  localparam logic [2:0] OP_ROL = 3'd7;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             accept;
  logic [WIDTH-1:0] n_pulses;
  logic             issue_act;
  logic             mismatch;

  assign cmd_ready = (state_q == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign n_pulses  = (cmd_op == OP_CLR || cmd_op == OP_LD) ? ONE : cmd_cnt;
  // Controls are gated by rst so a mid-command reset stops pulses in the same cycle.
  assign issue_act = (state_q == ISSUE) & ~rst;
  assign mismatch  = (reg_out != exp_q);

  assign done      = (state_q == CHECK) & ~rst;
  assign err       = done ? mismatch : err_q;
  assign exp_val   = exp_q;
  assign err_count = err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_CLR;
      arg_q     <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= cmd_op;
        arg_q <= cmd_arg;
        cnt_q <= n_pulses;
      end
      if (state_q == ISSUE) begin
        cnt_q <= cnt_q - ONE;
        exp_q <= exp_d;
      end
      if (state_q == CHECK) begin
        err_q <= mismatch;
        if (mismatch && (err_cnt_q != {ERR_W{1'b1}}))
          err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = (n_pulses == '0) ? CHECK : ISSUE;
      end
      ISSUE: begin
        if (cnt_q == ONE)
          state_d = CHECK;
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow model step and the matching control pulse for the latched op.
  // Rotates reuse the shift controls with the serial bit taken from the model.
  always_comb begin
    exp_d   = exp_q;
    reg_cl  = 1'b0;
    reg_ld  = 1'b0;
    reg_inc = 1'b0;
    reg_dec = 1'b0;
    reg_sr  = 1'b0;
    reg_ir  = 1'b0;
    reg_sl  = 1'b0;
    reg_il  = 1'b0;
    reg_in  = '0;
    case (op_q)
      OP_CLR: begin
        exp_d  = '0;
        reg_cl = issue_act;
      end
      OP_LD: begin
        exp_d  = arg_q;
        reg_ld = issue_act;
        reg_in = issue_act ? arg_q : '0;
      end
      OP_INC: begin
        exp_d   = exp_q + ONE;
        reg_inc = issue_act;
      end
      OP_DEC: begin
        exp_d   = exp_q - ONE;
        reg_dec = issue_act;
      end
      OP_SHR: begin
        exp_d  = {arg_q[0], exp_q[WIDTH-1:1]};
        reg_sr = issue_act;
        reg_ir = issue_act & arg_q[0];
      end
      OP_SHL: begin
        exp_d  = {exp_q[WIDTH-2:0], arg_q[0]};
        reg_sl = issue_act;
        reg_il = issue_act & arg_q[0];
      end
      OP_ROR: begin
        exp_d  = {exp_q[0], exp_q[WIDTH-1:1]};
        reg_sr = issue_act;
        reg_ir = issue_act & exp_q[0];
      end
      OP_ROL: begin
        exp_d  = {exp_q[WIDTH-2:0], exp_q[WIDTH-1]};
        reg_sl = issue_act;
        reg_il = issue_act & exp_q[WIDTH-1];
      end
      default: exp_d = exp_q;
    endcase
  end

endmodule

// File: tb/tb_reg_cmd_driver.sv
// Testbench for reg_cmd_driver: behavioural register, scoreboard of expected
// per-command results, and a negedge monitor that checks pulses and results.
module tb_reg_cmd_driver;
  localparam int W  = 4;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_arg;
  logic [W-1:0]  cmd_cnt;
  logic          reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [W-1:0]  reg_in;
  logic [W-1:0]  reg_out;
  logic          done;
  logic          err;
  logic [W-1:0]  exp_val;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  reg_cmd_driver #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_cnt(cmd_cnt),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
    .reg_in(reg_in), .reg_out(reg_out), .done(done), .err(err),
    .exp_val(exp_val), .err_count(err_count)
  );

  // Behavioural 4-bit control register; stuck forces its visible output to 0.
  logic [W-1:0] r_val;
  bit           stuck = 0;
  assign reg_out = stuck ? '0 : r_val;

  always @(posedge clk) begin
    if (rst)          r_val <= '0;
    else if (reg_cl)  r_val <= '0;
    else if (reg_ld)  r_val <= reg_in;
    else if (reg_inc) r_val <= r_val + 1'b1;
    else if (reg_dec) r_val <= r_val - 1'b1;
    else if (reg_sr)  r_val <= {reg_ir, r_val[W-1:1]};
    else if (reg_sl)  r_val <= {r_val[W-2:0], reg_il};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  typedef struct {
    int op;
    int arg;
    int n;
    int val;
    int err;
    int cnt;
  } item_t;

  item_t sb[$];
  int    m_val    = 0;
  int    m_errcnt = 0;

  function automatic int npulse(input int op, input int cnt);
    return (op <= 1) ? 1 : cnt;
  endfunction

  // Final register value after a whole command, by closed-form arithmetic.
  function automatic int ref_final(input int op, input int arg, input int cnt, input int m);
    int b;
    int k;
    b = arg & 1;
    k = cnt % 4;
    case (op)
      0: return 0;
      1: return arg & 15;
      2: return (m + cnt) & 15;
      3: return (m - cnt) & 15;
      4: if (cnt >= 4) return b ? 15 : 0;
         else return (m >> cnt) | (b ? ((15 << (4 - cnt)) & 15) : 0);
      5: if (cnt >= 4) return b ? 15 : 0;
         else return ((m << cnt) & 15) | (b ? ((1 << cnt) - 1) : 0);
      6: return ((m >> k) | (m << (4 - k))) & 15;
      default: return ((m << k) | (m >> (4 - k))) & 15;
    endcase
  endfunction

  function automatic int ctl_mask(input int op);
    case (op)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      4, 6: return 16;
      default: return 32;
    endcase
  endfunction

  task automatic send(input int op, input int arg, input int cnt);
    int    budget;
    item_t it;
    @(posedge clk); #1;
    budget = 0;
    while (!cmd_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", cmd_ready, 1);
      return;
    end
    it.op  = op;
    it.arg = arg & 15;
    it.n   = npulse(op, cnt);
    it.val = ref_final(op, arg, cnt, m_val);
    it.err = (stuck && it.val != 0) ? 1 : 0;
    it.cnt = (m_errcnt + it.err > 255) ? 255 : m_errcnt + it.err;
    m_val    = it.val;
    m_errcnt = it.cnt;
    sb.push_back(it);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_arg   = W'(arg);
    cmd_cnt   = W'(cnt);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_arg   = W'($urandom_range(0, 15));
    cmd_cnt   = W'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor
  bit    busy = 0;
  bit    pend = 0;
  int    pend_cnt, pend_err;
  int    lat, pulses;
  item_t cur;

  always @(negedge clk) begin
    logic [5:0] ctl;
    ctl = {reg_sl, reg_sr, reg_dec, reg_inc, reg_ld, reg_cl};
    if (rst) begin
      busy = 0;
      pend = 0;
    end else begin
      if (pend) begin
        check("err_count", err_count, pend_cnt);
        check("err_hold", err, pend_err);
        check("ready_after_done", cmd_ready, 1);
        pend = 0;
      end
      if (busy) begin
        lat++;
        check("onehot", ($countones(ctl) <= 1), 1);
        if (ctl != 0) begin
          pulses++;
          check("pulse_kind", ctl, ctl_mask(cur.op));
          check("reg_in", reg_in, (cur.op == 1) ? cur.arg : 0);
          if (cur.op == 4) check("ir_bit", reg_ir, cur.arg & 1);
          if (cur.op == 5) check("il_bit", reg_il, cur.arg & 1);
        end
        if (done) begin
          check("pulses", pulses, cur.n);
          check("latency", lat, cur.n + 1);
          check("exp_val", exp_val, cur.val);
          check("err", err, cur.err);
          void'(sb.pop_front());
          pend     = 1;
          pend_cnt = cur.cnt;
          pend_err = cur.err;
          busy     = 0;
        end else if (lat > 40) begin
          check("done_timeout", 0, 1);
          void'(sb.pop_front());
          busy = 0;
        end
      end else begin
        check("idle_quiet", {26'd0, ctl} + done, 0);
      end
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty_on_accept", 0, 1);
        end else begin
          cur    = sb[sb.size() - 1];
          busy   = 1;
          lat    = 0;
          pulses = 0;
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_arg   = '0;
    cmd_cnt   = '0;
    @(posedge clk); #1;
    check("rst_ready", cmd_ready, 0);
    @(posedge clk); #1;
    check("rst_exp_val", exp_val, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready, 1);

    send(1, 9, 0);
    send(1, 14, 0);
    send(2, 0, 3);
    send(1, 0, 0);
    send(3, 0, 1);
    send(1, 11, 0);
    send(6, 0, 2);
    send(5, 1, 0);
    wait_idle();

    stuck = 1;
    send(1, 5, 0);
    send(0, 0, 0);
    wait_idle();
    stuck = 0;

    for (int i = 0; i < 150; i++) begin
      send($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end
    wait_idle();

    stuck = 1;
    send(1, 5, 0);
    for (int i = 0; i < 260; i++) send(5, 0, 0);
    wait_idle();
    stuck = 0;

    send(2, 0, 10);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_no_pulse", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}, 0);
    check("abort_ready", cmd_ready, 0);
    sb.delete();
    m_val    = 0;
    m_errcnt = 0;
    @(posedge clk); #1;
    check("abort_exp_val", exp_val, 0);
    check("abort_err_count", err_count, 0);
    rst = 1'b0;
    #1;
    check("abort_ready_back", cmd_ready, 1);

    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 6));
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
